inst_mem_dbuf: RTL and testbench

Double-buffered (ping-pong) instruction memory for the packet-filter CPU. Two banks of `2**ADDR_WIDTH` words: the CPU fetches from the active bank while the loader writes a new program into the shadow bank. A commit handshake swaps the banks only when the CPU is idle, so a filter program is never replaced mid-packet. It also tracks program length and flags fetches past the end of the loaded program.

---
 rtl/inst_mem_dbuf.sv | 143 ++++++++++++++
 tb/tb_inst_mem_dbuf.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_dbuf.sv
// inst_mem_dbuf: ping-pong instruction memory for the packet-filter CPU.
// The CPU fetches from the active bank while the loader fills the shadow bank.
// A commit swaps the banks once the CPU is idle and not fetching.
// Optional build macro INST_MEM_DEFAULT_PROG_EN preloads word 0 of both banks
// with an accept-all program and resets prog_len to 1.
module inst_mem_dbuf #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  wr_commit,
  output logic                  commit_pending,
  input  logic                  cpu_idle,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_oob,
  output logic                  active_bank,
  output logic [ADDR_WIDTH:0]   prog_len
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    LOAD    = 1'b0,
    PENDING = 1'b1
  } state_t;

  typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];

`ifdef INST_MEM_DEFAULT_PROG_EN
  localparam logic [ADDR_WIDTH:0] PROG_LEN_RST = (ADDR_WIDTH+1)'(1);

  // Power-up image: word 0 holds "ret #65535" so a fresh filter accepts all.
  function automatic mem_t default_image();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) m[i] = '0;
    m[0] = DATA_WIDTH'(64'h000600000000FFFF);
    return m;
  endfunction

  mem_t mem0 = default_image();
  mem_t mem1 = default_image();
`else
  localparam logic [ADDR_WIDTH:0] PROG_LEN_RST = '0;

  mem_t mem0;
  mem_t mem1;
`endif

  state_t                state_q, state_d;
  logic                  swap;
  logic                  wr_ok;
  logic                  we0, we1, re0, re1;
  logic                  rd_sel;
  logic [ADDR_WIDTH:0]   shadow_len;
  logic [ADDR_WIDTH:0]   wr_len;
  logic [DATA_WIDTH-1:0] q0, q1;

  assign wr_len = {1'b0, wr_addr} + (ADDR_WIDTH+1)'(1);

  // Each RAM sees the raw ports; bank selection lives only in the enables,
  // so the address paths stay mux-free.
  assign we0 = wr_ok &  active_bank;
  assign we1 = wr_ok & ~active_bank;
  assign re0 = rd_en & ~active_bank;
  assign re1 = rd_en &  active_bank;

  assign commit_pending = (state_q == PENDING);
  assign rd_data        = rd_sel ? q1 : q0;

  // Next-state logic: loads accepted in LOAD, swap only when idle and not fetching.
  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    wr_ok   = 1'b0;
    case (state_q)
      LOAD: begin
        wr_ok = wr_en;
        if (wr_commit) state_d = PENDING;
      end
      PENDING: begin
        if (cpu_idle && !rd_en) begin
          swap    = 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Control registers: FSM, bank select, program lengths and fetch flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      active_bank <= 1'b0;
      prog_len    <= PROG_LEN_RST;
      shadow_len  <= '0;
      rd_sel      <= 1'b0;
      rd_oob      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (swap) begin
        active_bank <= ~active_bank;
        prog_len    <= shadow_len;
        shadow_len  <= '0;
      end else if (wr_ok && (wr_len > shadow_len)) begin
        shadow_len <= wr_len;
      end
      if (rd_en) begin
        rd_sel <= active_bank;
        rd_oob <= ({1'b0, rd_addr} >= prog_len);
      end
    end
  end

  // Bank 0 write port.
  always_ff @(posedge clk) begin
    if (we0) mem0[wr_addr] <= wr_data;
  end

  // Bank 0 registered read port with clock enable.
  always_ff @(posedge clk) begin
    if (rst)      q0 <= '0;
    else if (re0) q0 <= mem0[rd_addr];
  end

  // Bank 1 write port.
  always_ff @(posedge clk) begin
    if (we1) mem1[wr_addr] <= wr_data;
  end

  // Bank 1 registered read port with clock enable.
  always_ff @(posedge clk) begin
    if (rst)      q1 <= '0;
    else if (re1) q1 <= mem1[rd_addr];
  end

endmodule

// File: tb/tb_inst_mem_dbuf.sv
// Testbench for inst_mem_dbuf: directed load/commit/fetch scenarios checked
// every cycle against a behavioural model, plus literal expectations.
module tb_inst_mem_dbuf;

  localparam int AW    = 10;
  localparam int DW    = 64;
  localparam int DEPTH = 1 << AW;

`ifdef INST_MEM_DEFAULT_PROG_EN
  localparam int DFLT_LEN = 1;
`else
  localparam int DFLT_LEN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          wr_commit;
  logic          commit_pending;
  logic          cpu_idle;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_oob;
  logic          active_bank;
  logic [AW:0]   prog_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_mem_dbuf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_commit(wr_commit),
    .commit_pending(commit_pending), .cpu_idle(cpu_idle),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_oob(rd_oob),
    .active_bank(active_bank), .prog_len(prog_len)
  );

  // Behavioural model: two word arrays, a pending flag and two lengths.
  logic [DW-1:0] m_mem   [2][DEPTH];
  bit            m_known [2][DEPTH];
  bit            m_booted = 0;
  bit            m_valid  = 0;
  bit            m_act, m_pend, m_oob, m_rd_known;
  int unsigned   m_plen, m_slen;
  logic [DW-1:0] m_rd;

  always @(posedge clk) begin
    if (!m_booted) begin
      m_booted <= 1;
`ifdef INST_MEM_DEFAULT_PROG_EN
      for (int b = 0; b < 2; b++) begin
        m_mem[b][0]   <= 64'h000600000000FFFF;
        m_known[b][0] <= 1;
      end
`endif
    end
    if (rst) begin
      m_valid    <= 1;
      m_act      <= 0;
      m_pend     <= 0;
      m_plen     <= DFLT_LEN;
      m_slen     <= 0;
      m_rd       <= '0;
      m_rd_known <= 1;
      m_oob      <= 0;
    end else begin
      if (rd_en) begin
        m_rd       <= m_mem[m_act][rd_addr];
        m_rd_known <= m_known[m_act][rd_addr];
        m_oob      <= (int'(rd_addr) >= m_plen);
      end
      if (!m_pend) begin
        if (wr_en) begin
          m_mem[!m_act][wr_addr]   <= wr_data;
          m_known[!m_act][wr_addr] <= 1;
          if (int'(wr_addr) + 1 > m_slen) m_slen <= int'(wr_addr) + 1;
        end
        if (wr_commit) m_pend <= 1;
      end else if (cpu_idle && !rd_en) begin
        m_act  <= !m_act;
        m_plen <= m_slen;
        m_slen <= 0;
        m_pend <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cmp_model();
    if (m_valid) begin
      chk("model_active_bank", 64'(active_bank), 64'(m_act));
      chk("model_commit_pending", 64'(commit_pending), 64'(m_pend));
      chk("model_prog_len", 64'(prog_len), 64'(m_plen));
      chk("model_rd_oob", 64'(rd_oob), 64'(m_oob));
      if (m_rd_known) chk("model_rd_data", rd_data, m_rd);
    end
  endtask

  // Advance one edge and compare against the model away from the edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic quiet();
    wr_en = 0; wr_commit = 0; rd_en = 0; cpu_idle = 0;
  endtask

  task automatic wr(input int a, input logic [63:0] d, input bit commit, input bit idle);
    wr_addr = AW'(a); wr_data = d; wr_en = 1; wr_commit = commit; cpu_idle = idle; rd_en = 0;
    tick();
    quiet();
  endtask

  task automatic rd(input int a);
    rd_addr = AW'(a); rd_en = 1;
    tick();
    rd_en = 0;
  endtask

  initial begin
    rst = 1; wr_addr = '0; wr_data = '0; rd_addr = '0;
    quiet();
    tick();
    tick();
    chk("reset_active_bank", 64'(active_bank), 64'd0);
    chk("reset_pending", 64'(commit_pending), 64'd0);
    chk("reset_rd_data", rd_data, 64'd0);
    rst = 0;

    // Fetch before any commit.
    rd(0);
`ifdef INST_MEM_DEFAULT_PROG_EN
    chk("fresh_rd_data", rd_data, 64'h000600000000FFFF);
    chk("fresh_oob", 64'(rd_oob), 64'd0);
    chk("fresh_prog_len", 64'(prog_len), 64'd1);
`else
    chk("fresh_oob", 64'(rd_oob), 64'd1);
    chk("fresh_prog_len", 64'(prog_len), 64'd0);
`endif

    // Load 4 words, commit while idle: swap two edges after the commit.
    for (int i = 0; i < 4; i++) wr(i, 64'hA0 + 64'(i), 0, 0);
    wr_commit = 1; cpu_idle = 1;
    tick();
    wr_commit = 0;
    chk("commit_pending_rise", 64'(commit_pending), 64'd1);
    chk("no_early_swap", 64'(active_bank), 64'd0);
    tick();
    chk("swap1_bank", 64'(active_bank), 64'd1);
    chk("swap1_len", 64'(prog_len), 64'd4);
    chk("swap1_pending", 64'(commit_pending), 64'd0);
    cpu_idle = 0;
    rd(2);
    chk("fetch2", rd_data, 64'hA2);
    chk("fetch2_oob", 64'(rd_oob), 64'd0);
    rd(4);
    chk("fetch4_oob", 64'(rd_oob), 64'd1);

    // Commit while busy: old program stays visible until idle.
    wr(0, 64'hB0, 0, 0);
    wr(1, 64'hB1, 0, 0);
    wr_commit = 1; rd_addr = AW'(2); rd_en = 1;
    tick();
    wr_commit = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("busy_pending", 64'(commit_pending), 64'd1);
      chk("busy_old_prog", rd_data, 64'hA2);
    end
    rd_en = 0; cpu_idle = 1;
    tick();
    cpu_idle = 0;
    chk("swap2_bank", 64'(active_bank), 64'd0);
    chk("swap2_len", 64'(prog_len), 64'd2);

    // rd_en defers the swap; writes while pending are dropped.
    wr(0, 64'hC0, 0, 0);
    wr_commit = 1; cpu_idle = 1; rd_addr = AW'(1); rd_en = 1;
    tick();
    wr_commit = 0;
    for (int i = 0; i < 5; i++) begin
      wr_en = (i == 2); wr_addr = '0; wr_data = 64'hFF;
      tick();
      chk("rd_defers_swap", 64'(active_bank), 64'd0);
      chk("rd_defers_data", rd_data, 64'hB1);
    end
    wr_en = 0; rd_en = 0;
    tick();
    cpu_idle = 0;
    chk("swap3_bank", 64'(active_bank), 64'd1);
    chk("swap3_len", 64'(prog_len), 64'd1);
    rd(0);
    chk("pending_write_ignored", rd_data, 64'hC0);
    rd(1);
    chk("stale_word_oob", 64'(rd_oob), 64'd1);
    chk("stale_word_data", rd_data, 64'hA1);

    // Top address written together with commit: full-depth program length.
    wr(DEPTH - 1, 64'hD00D, 1, 1);
    chk("wr_commit_same_cycle", 64'(commit_pending), 64'd1);
    cpu_idle = 1;
    tick();
    cpu_idle = 0;
    chk("full_len", 64'(prog_len), 64'(DEPTH));
    chk("swap4_bank", 64'(active_bank), 64'd0);
    rd(DEPTH - 1);
    chk("top_word", rd_data, 64'hD00D);
    chk("top_oob", 64'(rd_oob), 64'd0);

    // Reset while a second commit is pending.
    wr(5, 64'hE5, 1, 0);
    tick();
    chk("second_pending", 64'(commit_pending), 64'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_bank", 64'(active_bank), 64'd0);
    chk("rst_pending", 64'(commit_pending), 64'd0);
    chk("rst_len", 64'(prog_len), 64'(DFLT_LEN));
    tick();
    rd(0);
`ifndef INST_MEM_DEFAULT_PROG_EN
    chk("ram_survives_rst", rd_data, 64'hB0);
    chk("post_rst_oob", 64'(rd_oob), 64'd1);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
